load_word_extract: RTL and testbench
====================================

// Module: load_word_extract
// PURPOSE
//  Memory-stage load unit. Reads an aligned 32-bit word from word-wide data memory.
//  Extracts the addressed byte, half-word or word (little endian), then zero- or sign-extends it.
//  Returns the result to writeback through a valid/ready handshake.
//  Read-side counterpart of the store byte/half-word merge path.
// PARAMETERS
//  ADDR_WIDTH      32   byte-address width of req_addr / mem_addr
//  TAG_WIDTH       5    width of destination-register tag carried with the request
//  TIMEOUT_CYCLES  255  max cycles in WAIT_DATA without mem_rvalid before error (>=1)
// PORTS
//  clk          in   1           clock, all logic on rising edge
//  rst          in   1           synchronous reset, active-high
//  req_valid    in   1           load request present
//  req_ready    out  1           unit can accept a request (1 only in IDLE)
//  req_addr     in   ADDR_WIDTH  byte address
//  req_type     in   3           0=LB 1=LBU 2=LH 3=LHU 4=LW, 5..7 illegal
//  req_dest     in   TAG_WIDTH   destination tag, echoed on resp_dest
//  mem_req      out  1           memory read request, held until mem_gnt
//  mem_addr     out  ADDR_WIDTH  {req_addr[ADDR_WIDTH-1:2],2'b00}
//  mem_gnt      in   1           memory accepted request this cycle
//  mem_rvalid   in   1           mem_rdata valid this cycle
//  mem_rdata    in   32          full word read
//  resp_valid   out  1           result available
//  resp_ready   in   1           consumer takes result this cycle
//  resp_data    out  32          extended load result
//  resp_dest    out  TAG_WIDTH   tag of this result
//  resp_err     out  1           misaligned/illegal/timeout; resp_data=0 when set
//  busy         out  1           state!=IDLE, pipeline stall
// BEHAVIOUR
//  Reset: state=IDLE. mem_req, mem_addr, resp_valid, resp_data, resp_dest, resp_err and timeout count = 0.
//   rst has priority over all events, including mid-transaction: the next cycle is IDLE with mem_req=0.
//  All outputs registered except req_ready=(state==IDLE) and busy=(state!=IDLE).
//  FSM IDLE -> REQ -> WAIT_DATA -> RESP -> IDLE:
//   IDLE: on req_valid, latch addr[1:0], type and dest.
//    Legal and aligned: go to REQ with mem_req=1 and mem_addr=word address.
//    LH/LHU with addr[0]=1, LW with addr[1:0]!=0, or type 5..7: no memory access.
//     Go to RESP with resp_err=1, resp_data=0.
//   REQ: hold mem_req and mem_addr stable until mem_gnt=1.
//    On that edge: mem_req=0, counter=0, go to WAIT_DATA.
//   WAIT_DATA: mem_rvalid is sampled only in this state.
//    On mem_rvalid: register the extracted data and go to RESP with resp_err=0.
//    Otherwise counter++. When counter reaches TIMEOUT_CYCLES-1 without rvalid:
//     go to RESP with resp_err=1, resp_data=0.
//   RESP: resp_valid=1. resp_data, resp_dest and resp_err are held stable until resp_ready.
//    On resp_ready: resp_valid=0, go to IDLE. No new request is accepted in the same cycle.
//  Stray mem_rvalid in IDLE, REQ or RESP (e.g. late data after timeout) is ignored.
//  Extraction, little endian, with a = latched addr[1:0]:
//   byte  = mem_rdata[8a+7 -: 8].  LB sign-extends bit 7. LBU zero-extends.
//   half  = a[1] ? mem_rdata[31:16] : mem_rdata[15:0].  LH sign-extends bit 15. LHU zero-extends.
//   LW    = mem_rdata unchanged.
//  Latency with zero-wait memory: accept T, mem_req T+1, gnt T+1, rvalid T+2, resp_valid T+3.
//   Error path: resp_valid at T+1.
// TESTING
//  1. LB at 0x1003, rdata 0x80FF1234 -> resp_data 0xFFFFFF80.
//     LBU same -> 0x00000080. LB at 0x1000 -> 0x00000034.
//  2. rdata 0x80017FFF: LH at 0x2002 -> 0xFFFF8001. LHU 0x2002 -> 0x00008001.
//     LH at 0x2000 -> 0x00007FFF. LW 0x2000 -> 0x80017FFF.
//  3. LW at 0x3001, LH at 0x3003, type 6 at 0x3000 -> mem_req never rises.
//     resp_valid at T+1, resp_err=1, resp_data=0.
//  4. mem_gnt withheld 3 cycles, rvalid 2 cycles after gnt, resp_ready low 4 cycles.
//     -> mem_addr and mem_req stable until gnt. Response fields stable while resp_valid && !resp_ready.
//     req_ready=0 and busy=1 throughout.
//  5. TIMEOUT_CYCLES=4, no rvalid -> resp_err=1 after 4 WAIT_DATA cycles.
//     rvalid pulsed 2 cycles later -> ignored; next LW returns correct data.
//  6. rst pulsed in WAIT_DATA, then in RESP -> next cycle IDLE.
//     All registered outputs 0, req_ready=1. A following LBU completes normally.

Source files
------------

// File: rtl/load_word_extract.sv
// Memory-stage load unit: fetches an aligned word, extracts the addressed byte/half/word,
// sign- or zero-extends it, and returns it to writeback over a valid/ready handshake.
module load_word_extract #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TAG_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_type,
  input  logic [TAG_WIDTH-1:0]  req_dest,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [TAG_WIDTH-1:0]  resp_dest,
  output logic                  resp_err,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, RESP} state_t;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LW  = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [1:0]       lat_off;
  logic [2:0]       lat_type;
  logic [CNT_W-1:0] cnt;
  logic             req_illegal;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_data;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Misaligned halves/words and the unused type codes never touch memory.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_illegal = 1'b0;
    unique case (req_type)
      LD_LB, LD_LBU: req_illegal = 1'b0;
      LD_LH, LD_LHU: req_illegal = req_addr[0];
      LD_LW:         req_illegal = (req_addr[1:0] != 2'b00);
      default:       req_illegal = 1'b1;
    endcase
  end

  // Little-endian lane select, driven by the offset latched at accept time.
  always_comb begin
    byte_sel  = mem_rdata[8*lat_off +: 8];
    half_sel  = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    unique case (lat_type)
      LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  load_data = {24'h0, byte_sel};
      LD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  load_data = {16'h0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_off    <= '0;
      lat_type   <= '0;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_dest  <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lat_off   <= req_addr[1:0];
            lat_type  <= req_type;
            resp_dest <= req_dest;
            if (req_illegal) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else begin
              state    <= REQ;
              mem_req  <= 1'b1;
              mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state   <= WAIT_DATA;
            mem_req <= 1'b0;
            cnt     <= '0;
          end
        end
        WAIT_DATA: begin
          if (mem_rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= load_data;
          end else if (cnt == CNT_LAST) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_word_extract.sv
// Directed bench for load_word_extract: expected responses are queued at issue time
// and compared when the unit presents them; inputs change and outputs are sampled 1 ns after each edge.
module tb_load_word_extract;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [4:0]  req_dest;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_dest;
  logic        resp_err;
  logic        busy;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  load_word_extract #(
    .ADDR_WIDTH    (32),
    .TAG_WIDTH     (5),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_type  (req_type),
    .req_dest  (req_dest),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_dest (resp_dest),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_illegal(input logic [1:0] a, input logic [2:0] t);
    return (t > 3'd4) || ((t == 3'd2 || t == 3'd3) && a[0]) || (t == 3'd4 && a != 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] a, input logic [2:0] t,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * a);
    case (t)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {24'h0, sh[7:0]};
      3'd2:    return {{16{sh[15]}}, sh[15:0]};
      3'd3:    return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_data"}, resp_data, 0);
    check({tag, "_resp_dest"}, resp_dest, 0);
    check({tag, "_resp_err"}, resp_err, 0);
  endtask

  // Accept a request; the response it should eventually produce is queued here.
  task automatic t_issue(input logic [31:0] addr, input logic [2:0] typ,
                         input logic [4:0] dest, input logic [31:0] rdata);
    exp_t e;
    logic ill;
    ill    = is_illegal(addr[1:0], typ);
    e.err  = ill;
    e.data = ill ? 32'h0 : ref_load(addr[1:0], typ, rdata);
    e.dest = dest;
    sb.push_back(e);
    check("issue_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_type  = typ;
    req_dest  = dest;
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_type  = 3'($urandom);
    req_dest  = 5'($urandom);
    if (ill) begin
      check("err_no_mem_req", mem_req, 0);
    end else begin
      check("mem_req_rise", mem_req, 1);
      check("mem_addr_word", mem_addr, {addr[31:2], 2'b00});
      check("busy_after_accept", busy, 1);
    end
  endtask

  task automatic t_grant(input int delay);
    logic [31:0] a0;
    a0 = mem_addr;
    for (int i = 0; i < delay; i++) begin
      tick();
      check("mem_req_held", mem_req, 1);
      check("mem_addr_held", mem_addr, a0);
      check("req_ready_low_req", req_ready, 0);
      check("busy_req", busy, 1);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("mem_req_drop", mem_req, 0);
  endtask

  task automatic t_data(input int delay, input logic [31:0] rdata);
    for (int i = 0; i < delay; i++) begin
      mem_rdata = $urandom;
      tick();
      check("no_resp_wait", resp_valid, 0);
      check("busy_wait", busy, 1);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
  endtask

  // Hold resp_ready low (with stray rvalid) for ready_delay cycles, then compare and retire.
  task automatic t_resp(input int ready_delay);
    exp_t        e;
    logic [31:0] d0;
    logic [4:0]  t0;
    logic        r0;
    check("resp_valid_up", resp_valid, 1);
    check("resp_mem_req_low", mem_req, 0);
    d0 = resp_data;
    t0 = resp_dest;
    r0 = resp_err;
    for (int i = 0; i < ready_delay; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      tick();
      check("resp_valid_held", resp_valid, 1);
      check("resp_data_held", resp_data, d0);
      check("resp_dest_held", 32'(resp_dest), 32'(t0));
      check("resp_err_held", resp_err, r0);
      check("req_ready_low_resp", req_ready, 0);
    end
    mem_rvalid = 1'b0;
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check("resp_data", resp_data, e.data);
      check("resp_dest", 32'(resp_dest), 32'(e.dest));
      check("resp_err", resp_err, e.err);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_type   = 3'd4;
    req_addr   = 32'h0000_7000;
    tick();
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check("resp_valid_drop", resp_valid, 0);
    check("back_to_idle", req_ready, 1);
    check("no_accept_on_handshake", mem_req, 0);
  endtask

  task automatic t_load(input logic [31:0] addr, input logic [2:0] typ, input logic [4:0] dest,
                        input logic [31:0] rdata, input int gnt_dly, input int data_dly,
                        input int ready_dly);
    t_issue(addr, typ, dest, rdata);
    if (!is_illegal(addr[1:0], typ)) begin
      t_grant(gnt_dly);
      t_data(data_dly, rdata);
    end
    t_resp(ready_dly);
  endtask

  initial begin
    exp_t e;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_type   = '0;
    req_dest   = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Byte extraction, zero-wait memory
    t_load(32'h0000_1003, 3'd0, 5'd1, 32'h80FF_1234, 0, 0, 0);
    t_load(32'h0000_1003, 3'd1, 5'd2, 32'h80FF_1234, 0, 0, 0);
    t_load(32'h0000_1000, 3'd0, 5'd3, 32'h80FF_1234, 0, 0, 0);

    // Half-word and word extraction
    t_load(32'h0000_2002, 3'd2, 5'd4, 32'h8001_7FFF, 0, 0, 0);
    t_load(32'h0000_2002, 3'd3, 5'd5, 32'h8001_7FFF, 0, 0, 0);
    t_load(32'h0000_2000, 3'd2, 5'd6, 32'h8001_7FFF, 0, 0, 0);
    t_load(32'h0000_2000, 3'd4, 5'd7, 32'h8001_7FFF, 0, 0, 0);

    // Misaligned and illegal requests answer at T+1 without touching memory
    t_load(32'h0000_3001, 3'd4, 5'd8,  32'h0, 0, 0, 1);
    t_load(32'h0000_3003, 3'd2, 5'd9,  32'h0, 0, 0, 0);
    t_load(32'h0000_3000, 3'd6, 5'd10, 32'h0, 0, 0, 2);

    // Back-pressure on grant, data and response
    t_load(32'h0000_4000, 3'd4, 5'd11, 32'hA5C3_0F96, 3, 2, 4);
    t_load(32'h0000_4002, 3'd0, 5'd12, 32'hA5C3_0F96, 3, 2, 4);

    // Timeout after 4 WAIT_DATA cycles; late rvalid in RESP is ignored
    t_issue(32'h0000_5004, 3'd4, 5'd13, 32'h0);
    e      = sb.pop_back();
    e.err  = 1'b1;
    e.data = 32'h0;
    sb.push_back(e);
    t_grant(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("timeout_not_yet", resp_valid, 0);
    end
    tick();
    check("timeout_resp", resp_valid, 1);
    check("timeout_err", resp_err, 1);
    t_resp(3);
    t_load(32'h0000_5008, 3'd4, 5'd14, 32'h1357_9BDF, 0, 0, 0);

    // Reset while waiting for data
    t_issue(32'h0000_6000, 3'd4, 5'd15, 32'h0);
    t_grant(0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    check_reset_state("rst_wait");

    // Reset while holding a response
    t_issue(32'h0000_6004, 3'd4, 5'd16, 32'hCAFE_F00D);
    t_grant(0);
    t_data(0, 32'hCAFE_F00D);
    check("pre_rst_resp_valid", resp_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    check_reset_state("rst_resp");

    t_load(32'h0000_6001, 3'd1, 5'd17, 32'h0000_AB00, 0, 0, 0);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
